// File: rtl/util_adc_switch.sv
// util_adc_switch
// Receive-side sample steering: forwards each qualified ADC sample either to
// the capture FIFO or to the differential decoder. Every change of path goes
// through a guard window that drops GUARD_SAMPLES qualified samples, so that
// neither consumer sees a torn stream.
module util_adc_switch #(
  parameter int BYTE_WIDTH    = 16,
  parameter int GUARD_SAMPLES = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [BYTE_WIDTH*8-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    adc_enable,
  output logic                    adc_dovf,
  output logic [BYTE_WIDTH*8-1:0] fifo_data,
  output logic                    fifo_wren,
  input  logic                    fifo_ovf,
  output logic [BYTE_WIDTH*8-1:0] wr_data,
  output logic                    wr_valid,
  input  logic                    wr_enable,
  input  logic                    wr_ovf,
  output logic                    sel_diff
);

  localparam int CW = (GUARD_SAMPLES < 1) ? 1 : $clog2(GUARD_SAMPLES + 1);
  localparam logic [CW-1:0] GUARD_MAX = CW'(GUARD_SAMPLES);

  typedef enum logic [1:0] {
    FIFO_PATH     = 2'd0,
    GUARD_TO_DIFF = 2'd1,
    DIFF_PATH     = 2'd2,
    GUARD_TO_FIFO = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   cnt_inc;
  logic            s;

  assign s        = adc_valid & adc_enable;
  assign sel_diff = (state == DIFF_PATH);
  // Saturating increment: the counter never wraps even if held at the limit.
  assign cnt_inc  = (cnt == GUARD_MAX) ? cnt : cnt + 1'b1;

  // Path selection and guard counting; an abort request wins over counting.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      FIFO_PATH: begin
        if (wr_enable) begin
          state_nxt = (GUARD_SAMPLES == 0) ? DIFF_PATH : GUARD_TO_DIFF;
          cnt_nxt   = '0;
        end
      end
      GUARD_TO_DIFF: begin
        if (!wr_enable) begin
          state_nxt = FIFO_PATH;
          cnt_nxt   = '0;
        end else if (s) begin
          if (cnt_inc == GUARD_MAX) begin
            state_nxt = DIFF_PATH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      DIFF_PATH: begin
        if (!wr_enable) begin
          state_nxt = (GUARD_SAMPLES == 0) ? FIFO_PATH : GUARD_TO_FIFO;
          cnt_nxt   = '0;
        end
      end
      GUARD_TO_FIFO: begin
        if (wr_enable) begin
          state_nxt = DIFF_PATH;
          cnt_nxt   = '0;
        end else if (s) begin
          if (cnt_inc == GUARD_MAX) begin
            state_nxt = FIFO_PATH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = FIFO_PATH;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and guard counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FIFO_PATH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sample registers and strobes; routing uses the state current in the sample cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_data <= '0;
      wr_data   <= '0;
      fifo_wren <= 1'b0;
      wr_valid  <= 1'b0;
    end else begin
      fifo_wren <= s & (state == FIFO_PATH);
      wr_valid  <= s & (state == DIFF_PATH);
      if (s) begin
        fifo_data <= adc_data;
        wr_data   <= adc_data;
      end
    end
  end

  // Overflow back to the ADC core follows whichever consumer(s) may be active.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adc_dovf <= 1'b0;
    end else begin
      case (state)
        FIFO_PATH: adc_dovf <= fifo_ovf;
        DIFF_PATH: adc_dovf <= wr_ovf;
        default:   adc_dovf <= fifo_ovf | wr_ovf;
      endcase
    end
  end

endmodule
